// File: rtl/vp_key_event_queue_if.sv
// Consumer-side handshake of the key event queue: show-ahead head entry plus pop strobe.
// The queue drives through the master modport, vp_keymap consumes through the slave modport.
interface vp_key_event_queue_if;
    logic       rx_data_ready_o;
    logic [7:0] rx_ascii_o;
    logic       rx_released_o;
    logic       rx_read_i;

    modport master (
        output rx_data_ready_o,
        output rx_ascii_o,
        output rx_released_o,
        input  rx_read_i
    );

    modport slave (
        input  rx_data_ready_o,
        input  rx_ascii_o,
        input  rx_released_o,
        output rx_read_i
    );
endinterface

// File: rtl/vp_key_event_queue.sv
// Merges PS/2 key strobes and gamepad keypad digits into one ordered press/release FIFO.
// Joystick digits are reference counted across pads so a digit is released only when no pad holds it.
module vp_key_event_queue #(
    parameter int NUM_JOY = 2,
    parameter int DEPTH   = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   res_n_i,
    input  logic [10:0]            ps2_key_i,
    input  logic [NUM_JOY*10-1:0]  joy_numpad_i,
    vp_key_event_queue_if.master   rx,
    output logic                   overflow_o,
    output logic [AW:0]            level_o
);

    localparam int NB = NUM_JOY * 10;

    logic          r_toggle;
    logic          r_s1Valid;
    logic [7:0]    r_s1Ascii;
    logic          r_s1Released;

    logic [NB-1:0] r_prev;
    logic [NB-1:0] r_pending;
    logic [9:0]    r_reported;

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic          r_overflow;

    logic          r_outValid;
    logic [7:0]    r_outAscii;
    logic          r_outReleased;

    logic          w_decValid;
    logic [7:0]    w_decAscii;
    logic          w_unusedExtended;

    logic          w_anyPend;
    logic [NB-1:0] w_svcOneHot;
    logic [3:0]    w_svcDigit;
    logic [9:0]    w_held;
    logic          w_heldSel;
    logic          w_repSel;
    logic [7:0]    w_joyAscii;

    logic          w_full;
    logic          w_pop;
    logic          w_s1Write;
    logic          w_joySvc;
    logic          w_joyWrite;
    logic          w_write;
    logic [8:0]    w_wrData;
    logic [AW-1:0] w_rdNext;
    logic [AW:0]   w_levelAfterPop;
    logic [AW:0]   w_nextLevel;
    logic [8:0]    w_nextHead;

    // The extended-key flag carries no meaning for the console keyboard.
    assign w_unusedExtended = ps2_key_i[8];

    always_comb begin
        w_decValid = 1'b1;
        w_decAscii = 8'h00;
        case (ps2_key_i[7:0])
            8'h16: w_decAscii = "1";
            8'h1E: w_decAscii = "2";
            8'h26: w_decAscii = "3";
            8'h25: w_decAscii = "4";
            8'h2E: w_decAscii = "5";
            8'h36: w_decAscii = "6";
            8'h3D: w_decAscii = "7";
            8'h3E: w_decAscii = "8";
            8'h46: w_decAscii = "9";
            8'h45: w_decAscii = "0";
            8'h1C: w_decAscii = "a";
            8'h32: w_decAscii = "b";
            8'h21: w_decAscii = "c";
            8'h23: w_decAscii = "d";
            8'h24: w_decAscii = "e";
            8'h2B: w_decAscii = "f";
            8'h34: w_decAscii = "g";
            8'h33: w_decAscii = "h";
            8'h43: w_decAscii = "i";
            8'h3B: w_decAscii = "j";
            8'h42: w_decAscii = "k";
            8'h4B: w_decAscii = "l";
            8'h3A: w_decAscii = "m";
            8'h31: w_decAscii = "n";
            8'h44: w_decAscii = "o";
            8'h4D: w_decAscii = "p";
            8'h15: w_decAscii = "q";
            8'h2D: w_decAscii = "r";
            8'h1B: w_decAscii = "s";
            8'h2C: w_decAscii = "t";
            8'h3C: w_decAscii = "u";
            8'h2A: w_decAscii = "v";
            8'h1D: w_decAscii = "w";
            8'h22: w_decAscii = "x";
            8'h35: w_decAscii = "y";
            8'h1A: w_decAscii = "z";
            8'h29: w_decAscii = " ";
            8'h79: w_decAscii = "+";
            8'h7B: w_decAscii = "-";
            8'h7C: w_decAscii = "*";
            8'h4A: w_decAscii = "/";
            8'h55: w_decAscii = "=";
            8'h1F: w_decAscii = 8'h11;
            8'h27: w_decAscii = 8'h12;
            8'h5A: w_decAscii = 8'd10;
            8'h66: w_decAscii = 8'd8;
            default: w_decValid = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            r_toggle     <= ps2_key_i[10];
            r_s1Valid    <= 1'b0;
            r_s1Ascii    <= 8'h00;
            r_s1Released <= 1'b0;
        end else begin
            r_toggle     <= ps2_key_i[10];
            r_s1Valid    <= (ps2_key_i[10] != r_toggle) && w_decValid;
            r_s1Ascii    <= w_decAscii;
            r_s1Released <= ~ps2_key_i[9];
        end
    end

    // Descending scan so the lowest-index pending bit is the one left selected.
    always_comb begin
        w_anyPend   = 1'b0;
        w_svcOneHot = '0;
        w_svcDigit  = 4'd0;
        for (int j = NUM_JOY - 1; j >= 0; j--) begin
            for (int d = 9; d >= 0; d--) begin
                if (r_pending[j*10+d]) begin
                    w_anyPend          = 1'b1;
                    w_svcOneHot        = '0;
                    w_svcOneHot[j*10+d] = 1'b1;
                    w_svcDigit         = 4'(d);
                end
            end
        end
    end

    always_comb begin
        w_held = '0;
        for (int j = 0; j < NUM_JOY; j++) begin
            for (int d = 0; d < 10; d++) begin
                w_held[d] = w_held[d] | joy_numpad_i[j*10+d];
            end
        end
    end

    assign w_heldSel  = w_held[w_svcDigit];
    assign w_repSel   = r_reported[w_svcDigit];
    assign w_joyAscii = (w_svcDigit == 4'd9) ? "0" : 8'h31 + {4'b0000, w_svcDigit};

    assign w_full     = (r_level == (AW+1)'(DEPTH));
    assign w_pop      = rx.rx_read_i && (r_level != '0);
    assign w_s1Write  = r_s1Valid && (!w_full || w_pop);
    assign w_joySvc   = w_anyPend && !r_s1Valid && !w_full;
    assign w_joyWrite = w_joySvc && (w_heldSel != w_repSel);
    assign w_write    = w_s1Write || w_joyWrite;
    assign w_wrData   = w_s1Write ? {r_s1Released, r_s1Ascii} : {~w_heldSel, w_joyAscii};

    // A bit that changes again in its own service cycle stays pending via the OR term.
    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            r_prev     <= joy_numpad_i;
            r_pending  <= '0;
            r_reported <= '0;
        end else begin
            r_prev    <= joy_numpad_i;
            r_pending <= (r_pending & ~(w_joySvc ? w_svcOneHot : '0)) | (joy_numpad_i ^ r_prev);
            if (w_joyWrite) begin
                r_reported[w_svcDigit] <= w_heldSel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (res_n_i && w_write) begin
            r_mem[r_wrPtr] <= w_wrData;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= w_rdNext;
            end
            r_level    <= w_nextLevel;
            r_overflow <= r_overflow | (r_s1Valid && w_full && !w_pop);
        end
    end

    // Registered show-ahead head: a write into an empty (or emptying) FIFO bypasses the memory.
    assign w_rdNext        = r_rdPtr + AW'(1);
    assign w_levelAfterPop = r_level - {{AW{1'b0}}, w_pop};
    assign w_nextLevel     = w_levelAfterPop + {{AW{1'b0}}, w_write};

    always_comb begin
        w_nextHead = 9'h000;
        if (w_levelAfterPop == '0) begin
            if (w_write) begin
                w_nextHead = w_wrData;
            end
        end else begin
            w_nextHead = r_mem[w_pop ? w_rdNext : r_rdPtr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            r_outValid    <= 1'b0;
            r_outAscii    <= 8'h00;
            r_outReleased <= 1'b0;
        end else begin
            r_outValid    <= (w_nextLevel != '0);
            r_outAscii    <= w_nextHead[7:0];
            r_outReleased <= w_nextHead[8];
        end
    end

    assign rx.rx_data_ready_o = r_outValid;
    assign rx.rx_ascii_o      = r_outAscii;
    assign rx.rx_released_o   = r_outReleased;
    assign overflow_o         = r_overflow;
    assign level_o            = r_level;

endmodule

// File: tb/tb_vp_key_event_queue.sv
// Directed bench for vp_key_event_queue: stimulus pushes expected {released, ascii} entries,
// a monitor pops them as the consumer reads the show-ahead head.
module tb_vp_key_event_queue;

    logic        clk;
    logic        resN;
    logic [10:0] ps2Key;
    logic [19:0] joy;
    logic        overflow;
    logic [3:0]  level;
    logic        consumeEn;

    int checkCount;
    int errorCount;
    logic [8:0] expQ [$];

    vp_key_event_queue_if rxIf ();

    vp_key_event_queue #(
        .NUM_JOY(2),
        .DEPTH  (8)
    ) dut (
        .clk_i       (clk),
        .res_n_i     (resN),
        .ps2_key_i   (ps2Key),
        .joy_numpad_i(joy),
        .rx          (rxIf.master),
        .overflow_o  (overflow),
        .level_o     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Toggles the PS/2 strobe at a falling edge; expEvent=1 queues the hand-computed entry.
    task automatic applyStimulus(input logic [7:0] code, input logic pressed,
                                 input logic expEvent, input logic [7:0] expAscii);
        @(negedge clk);
        ps2Key = {~ps2Key[10], pressed, 1'b0, code};
        if (expEvent) expQ.push_back({~pressed, expAscii});
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int n);
        @(negedge clk);
        consumeEn = 1'b1;
        repeat (n) @(negedge clk);
        consumeEn = 1'b0;
        waitCycles(2);
    endtask

    // Consumer and scoreboard: whatever head is read at the next rising edge is compared now.
    always begin
        @(negedge clk);
        #1;
        rxIf.rx_read_i = consumeEn;
        if (consumeEn && rxIf.rx_data_ready_o) begin
            checkCount++;
            if (expQ.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL popEntry actual=%0h expected=none",
                         {rxIf.rx_released_o, rxIf.rx_ascii_o});
            end else begin
                logic [8:0] exp;
                exp = expQ.pop_front();
                if ({rxIf.rx_released_o, rxIf.rx_ascii_o} != exp) begin
                    errorCount++;
                    $display("[TB] FAIL popEntry actual=%0h expected=%0h",
                             {rxIf.rx_released_o, rxIf.rx_ascii_o}, exp);
                end
            end
        end
    end

    initial begin
        checkCount     = 0;
        errorCount     = 0;
        consumeEn      = 1'b0;
        rxIf.rx_read_i = 1'b0;
        resN           = 1'b0;
        ps2Key         = 11'h400;
        joy            = 20'h00010;
        waitCycles(3);
        resN = 1'b1;
        waitCycles(4);
        $display("[TB] reset with strobe high and pad0 digit 5 held");
        checkOutput("resetReady", rxIf.rx_data_ready_o, 0);
        checkOutput("resetLevel", level, 0);
        checkOutput("resetOverflow", overflow, 0);
        checkOutput("resetAscii", rxIf.rx_ascii_o, 0);
        joy = 20'h00000;
        waitCycles(4);
        checkOutput("unreportedRelease", level, 0);

        $display("[TB] PS/2 press and release of key 1");
        applyStimulus(8'h16, 1'b1, 1'b1, "1");
        waitCycles(1);
        checkOutput("ps2LatencyEarly", rxIf.rx_data_ready_o, 0);
        waitCycles(1);
        checkOutput("ps2LatencyReady", rxIf.rx_data_ready_o, 1);
        checkOutput("ps2HeadAscii", rxIf.rx_ascii_o, 8'h31);
        checkOutput("ps2HeadReleased", rxIf.rx_released_o, 0);
        applyStimulus(8'h16, 1'b0, 1'b1, "1");
        waitCycles(3);
        checkOutput("ps2TwoEntries", level, 2);
        applyStimulus(8'h76, 1'b1, 1'b0, 8'h00);
        waitCycles(3);
        checkOutput("ps2UnknownCode", level, 2);
        drain(4);
        checkOutput("drainedLevel", level, 0);

        $display("[TB] digit 3 held on both pads");
        @(negedge clk);
        joy = 20'h01004;
        expQ.push_back({1'b0, 8'h33});
        waitCycles(4);
        checkOutput("sharedPress", level, 1);
        joy = 20'h01000;
        waitCycles(4);
        checkOutput("stillHeldByPad1", level, 1);
        joy = 20'h00000;
        expQ.push_back({1'b1, 8'h33});
        waitCycles(4);
        checkOutput("lastPadReleases", level, 2);
        drain(4);

        $display("[TB] PS/2 a and pad0 digit 7 in one cycle");
        applyStimulus(8'h1C, 1'b1, 1'b1, "a");
        joy = 20'h00040;
        expQ.push_back({1'b0, 8'h37});
        waitCycles(2);
        checkOutput("priorityS1First", level, 1);
        waitCycles(1);
        checkOutput("priorityJoyNext", level, 2);
        checkOutput("priorityHead", rxIf.rx_ascii_o, 8'h61);
        joy = 20'h00000;
        expQ.push_back({1'b1, 8'h37});
        waitCycles(3);
        drain(5);

        $display("[TB] fill to depth and overflow");
        applyStimulus(8'h1C, 1'b1, 1'b1, "a");
        waitCycles(1);
        applyStimulus(8'h32, 1'b1, 1'b1, "b");
        waitCycles(1);
        applyStimulus(8'h21, 1'b1, 1'b1, "c");
        waitCycles(1);
        applyStimulus(8'h29, 1'b1, 1'b1, " ");
        waitCycles(1);
        applyStimulus(8'h79, 1'b1, 1'b1, "+");
        waitCycles(1);
        applyStimulus(8'h5A, 1'b1, 1'b1, 8'd10);
        waitCycles(1);
        applyStimulus(8'h66, 1'b1, 1'b1, 8'd8);
        waitCycles(1);
        applyStimulus(8'h45, 1'b1, 1'b1, "0");
        waitCycles(3);
        checkOutput("fullLevel", level, 8);
        checkOutput("noOverflowYet", overflow, 0);
        applyStimulus(8'h1F, 1'b1, 1'b0, 8'h11);
        waitCycles(3);
        checkOutput("overflowLevel", level, 8);
        checkOutput("overflowSticky", overflow, 1);
        applyStimulus(8'h27, 1'b1, 1'b1, 8'h12);
        @(negedge clk);
        consumeEn = 1'b1;
        @(negedge clk);
        consumeEn = 1'b0;
        waitCycles(2);
        checkOutput("writeWithPopLevel", level, 8);
        checkOutput("writeWithPopOverflow", overflow, 1);

        $display("[TB] digit 9 pulse while full");
        @(negedge clk);
        joy = 20'h00100;
        @(negedge clk);
        joy = 20'h00000;
        waitCycles(2);
        checkOutput("pulseWhileFull", level, 8);
        drain(12);
        checkOutput("pulseNoEvent", level, 0);
        checkOutput("scoreboardEmpty", expQ.size(), 0);

        $display("[TB] reset discards queued entries");
        applyStimulus(8'h2E, 1'b1, 1'b0, "5");
        waitCycles(3);
        checkOutput("preResetLevel", level, 1);
        @(negedge clk);
        resN = 1'b0;
        waitCycles(2);
        resN = 1'b1;
        waitCycles(3);
        checkOutput("postResetLevel", level, 0);
        checkOutput("postResetReady", rxIf.rx_data_ready_o, 0);
        checkOutput("postResetOverflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
